// File: rtl/vga_plot_arbiter.sv
// Two-requester round-robin pixel plotter with a full-screen clear sweep, driving a single
// video-memory write port through registered outputs.
module vga_plot_arbiter #(
    parameter int unsigned COLOUR_BITS = 3,
    parameter int unsigned X_MAX       = 320,
    parameter int unsigned Y_MAX       = 240
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_req,
    input  logic [COLOUR_BITS-1:0] clear_colour,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [8:0]             x0,
    input  logic [8:0]             x1,
    input  logic [7:0]             y0,
    input  logic [7:0]             y1,
    input  logic [COLOUR_BITS-1:0] c0,
    input  logic [COLOUR_BITS-1:0] c1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic [8:0]             vga_x,
    output logic [7:0]             vga_y,
    output logic [COLOUR_BITS-1:0] vga_colour,
    output logic                   vga_plot,
    output logic                   clear_busy,
    output logic                   clear_done
);

    localparam logic [8:0] XLast = 9'(X_MAX - 1);
    localparam logic [7:0] YLast = 8'(Y_MAX - 1);

    typedef enum logic [0:0] {StArb, StClear} state_e;

    state_e                 state_q, state_d;
    logic                   prio1_q, prio1_d;
    logic [8:0]             x_q, x_d;
    logic [7:0]             y_q, y_d;
    logic [COLOUR_BITS-1:0] colour_q, colour_d;
    logic                   plot_q, plot_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d  = state_q;
        prio1_d  = prio1_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        unique case (state_q)
            StArb: begin
                if (clear_req) begin
                    state_d  = StClear;
                    x_d      = 9'd0;
                    y_d      = 8'd0;
                    colour_d = clear_colour;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = (XLast == 9'd0) && (YLast == 8'd0);
                end else begin
                    // prio1_q set means requester 1 wins the next tie.
                    gnt0 = req0 && (!req1 || !prio1_q);
                    gnt1 = req1 && (!req0 || prio1_q);
                    if (gnt0) begin
                        prio1_d  = 1'b1;
                        x_d      = x0;
                        y_d      = y0;
                        colour_d = c0;
                        plot_d   = 1'b1;
                    end else if (gnt1) begin
                        prio1_d  = 1'b0;
                        x_d      = x1;
                        y_d      = y1;
                        colour_d = c1;
                        plot_d   = 1'b1;
                    end
                end
            end
            StClear: begin
                // The output registers double as the sweep counters.
                if (x_q == XLast && y_q == YLast) begin
                    state_d = StArb;
                end else begin
                    plot_d = 1'b1;
                    busy_d = 1'b1;
                    if (x_q == XLast) begin
                        x_d = 9'd0;
                        y_d = y_q + 8'd1;
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                    done_d = (x_d == XLast) && (y_d == YLast);
                end
            end
        endcase

        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StArb;
            prio1_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio1_q  <= prio1_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus queues expected plots, a monitor pops
// and compares one entry for every cycle the DUT asserts vga_plot.
module tb_vga_plot_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       req0, req1;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] c0, c1;
    logic       gnt0, gnt1;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, clear_busy, clear_done;

    always #5 clock = ~clock;

    vga_plot_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .req0         (req0),
        .req1         (req1),
        .x0           (x0),
        .x1           (x1),
        .y0           (y0),
        .y1           (y1),
        .c0           (c0),
        .c1           (c1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done)
    );

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_act, mon_exp;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c,
                        input logic busy, input logic done);
        pix_t p;
        p = '{x: x, y: y, c: c, busy: busy, done: done};
        exp_q.push_back(p);
    endtask

    // Push the sweep pixels in raster order, stopping after index last_idx.
    task automatic push_sweep(input logic [2:0] c, input int last_idx);
        int n;
        n = 0;
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x < 320; x++) begin
                if (n <= last_idx) push(9'(x), 8'(y), c, 1'b1, (x == 319) && (y == 239));
                n++;
            end
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (vga_plot === 1'b1) begin
                mon_act = {vga_x, vga_y, vga_colour, clear_busy, clear_done};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d busy=%0d done=%0d, expected no plot",
                             vga_x, vga_y, vga_colour, clear_busy, clear_done);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_errors++;
                        $display("FAIL plot_data: got x=%0d y=%0d c=%0d busy=%0d done=%0d, expected x=%0d y=%0d c=%0d busy=%0d done=%0d",
                                 mon_act.x, mon_act.y, mon_act.c, mon_act.busy, mon_act.done,
                                 mon_exp.x, mon_exp.y, mon_exp.c, mon_exp.busy, mon_exp.done);
                    end
                end
            end else if (clear_done === 1'b1) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_without_plot: got clear_done=1, expected 0");
            end
        end
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; clear_colour = 3'd0;
        req0 = 1'b1; req1 = 1'b0;
        x0 = 9'd0; y0 = 8'd0; c0 = 3'd0; x1 = 9'd0; y1 = 8'd0; c1 = 3'd0;
        tick();
        check("rst_gnt0", gnt0, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        reset = 1'b0; req0 = 1'b0;

        // Single requester, same-cycle grant, one-cycle plot latency.
        req0 = 1'b1; x0 = 9'd5; y0 = 8'd7; c0 = 3'b101;
        #1;
        check("single_gnt0", gnt0, 1);
        check("single_gnt1", gnt1, 0);
        push(9'd5, 8'd7, 3'b101, 1'b0, 1'b0);
        tick();
        req0 = 1'b0;
        #1;
        check("idle_gnt0", gnt0, 0);
        tick();
        check("idle_plot", vga_plot, 0);
        check("idle_hold_x", vga_x, 5);
        check("idle_hold_y", vga_y, 7);

        // Tie after reset: 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; x0 = 9'd10; y0 = 8'd20; c0 = 3'd1;
        req1 = 1'b1; x1 = 9'd30; y1 = 8'd40; c1 = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("tie_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) push(9'd10, 8'd20, 3'd1, 1'b0, 1'b0);
            else            push(9'd30, 8'd40, 3'd6, 1'b0, 1'b0);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Clear beats req1; sweep then aborted by reset at (100,50).
        req1 = 1'b1; clear_req = 1'b1; clear_colour = 3'b010;
        #1;
        check("clr_gnt1", gnt1, 0);
        check("clr_gnt0", gnt0, 0);
        push_sweep(3'b010, 50 * 320 + 100);
        tick();
        clear_req = 1'b0;
        #1;
        check("sweep_gnt1", gnt1, 0);
        check("sweep_first_busy", clear_busy, 1);
        req1 = 1'b0;
        for (int i = 1; i <= 50 * 320 + 100; i++) tick();
        check("abort_at_x", vga_x, 100);
        check("abort_at_y", vga_y, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_plot", vga_plot, 0);
        check("abort_x", vga_x, 0);
        check("abort_y", vga_y, 0);
        check("abort_colour", vga_colour, 0);
        check("abort_busy", clear_busy, 0);
        check("abort_done", clear_done, 0);

        // Full sweep with req0 held and a clear_req pulse mid-sweep.
        req0 = 1'b1; x0 = 9'd9; y0 = 8'd9; c0 = 3'd7;
        clear_req = 1'b1; clear_colour = 3'b110;
        #1;
        check("full_clr_gnt0", gnt0, 0);
        push_sweep(3'b110, 76799);
        push(9'd9, 8'd9, 3'd7, 1'b0, 1'b0);
        tick();
        clear_req = 1'b0;
        for (int i = 1; i < 76800; i++) begin
            if (i == 30000) begin
                clear_req = 1'b1;
                #1;
                check("mid_gnt0", gnt0, 0);
            end
            tick();
            clear_req = 1'b0;
        end
        check("last_x", vga_x, 319);
        check("last_y", vga_y, 239);
        check("last_busy", clear_busy, 1);
        check("last_done", clear_done, 1);
        #1;
        check("last_gnt0", gnt0, 0);
        tick();
        check("end_busy", clear_busy, 0);
        check("end_done", clear_done, 0);
        #1;
        check("resume_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
